// File: rtl/load_store_unit_if.sv
// Bundles the EX-stage request, data-memory port and writeback signals of
// the load/store unit. The slave view is the unit itself; the master view is
// the surrounding pipeline plus data memory.
interface load_store_unit_if #(
    parameter int ADDR_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic [5:0]        opcode;
    logic [31:0]       alu_result;
    logic [31:0]       rt_data;
    logic [4:0]        dest_reg;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_be;
    logic              mem_read;
    logic              mem_write;
    logic [31:0]       mem_rdata;
    logic              wb_valid;
    logic [4:0]        wb_reg;
    logic [31:0]       wb_data;
    logic              misalign_err;

    modport slave (
        input  req_valid, opcode, alu_result, rt_data, dest_reg, mem_rdata,
        output req_ready, mem_addr, mem_wdata, mem_be, mem_read, mem_write,
               wb_valid, wb_reg, wb_data, misalign_err
    );

    modport master (
        output req_valid, opcode, alu_result, rt_data, dest_reg, mem_rdata,
        input  req_ready, mem_addr, mem_wdata, mem_be, mem_read, mem_write,
               wb_valid, wb_reg, wb_data, misalign_err
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one MIPS load/store at a time from EX, drives a
// word-addressed data memory with byte enables, and returns extended load
// data to writeback. Misaligned halfword/word accesses are dropped with a
// one-cycle fault pulse.
module load_store_unit #(
    parameter int ADDR_W      = 8,
    parameter int MEM_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    load_store_unit_if.slave  bus
);
    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;
    localparam logic [3:0] LAT    = 4'(MEM_LATENCY);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t            state_r, state_s;
    logic [3:0]        cnt_r, cnt_s;
    logic [5:0]        op_r, op_s;
    logic [1:0]        off_r, off_s;
    logic [4:0]        dest_r, dest_s;
    logic [ADDR_W-1:0] mem_addr_r, mem_addr_s;
    logic [31:0]       mem_wdata_r, mem_wdata_s;
    logic [3:0]        mem_be_r, mem_be_s;
    logic              mem_read_r, mem_read_s;
    logic              mem_write_r, mem_write_s;
    logic              wb_valid_r, wb_valid_s;
    logic [4:0]        wb_reg_r, wb_reg_s;
    logic [31:0]       wb_data_r, wb_data_s;
    logic              misalign_r, misalign_s;

    logic              is_load_s, is_store_s, bad_align_s;
    logic [3:0]        st_be_s;
    logic [31:0]       st_wdata_s;

    // Upper byte-address bits fall outside the memory and wrap away.
    logic              unused_addr_s;
    assign unused_addr_s = ^bus.alu_result[31:ADDR_W+2];

    // Select the addressed byte/halfword and sign- or zero-extend it.
    function automatic logic [31:0] extract_load(
        input logic [5:0]  op,
        input logic [1:0]  off,
        input logic [31:0] rdata
    );
        logic [7:0]  b;
        logic [15:0] h;
        b = rdata[{off, 3'b000} +: 8];
        h = off[1] ? rdata[31:16] : rdata[15:0];
        case (op)
            OP_LB:   extract_load = {{24{b[7]}}, b};
            OP_LBU:  extract_load = {24'h000000, b};
            OP_LH:   extract_load = {{16{h[15]}}, h};
            OP_LHU:  extract_load = {16'h0000, h};
            OP_LW:   extract_load = rdata;
            default: extract_load = 32'h00000000;
        endcase
    endfunction

    // Classify the incoming opcode and build store lanes and alignment fault.
    always_comb begin
        is_load_s   = 1'b0;
        is_store_s  = 1'b0;
        bad_align_s = 1'b0;
        st_be_s     = 4'b1111;
        st_wdata_s  = bus.rt_data;
        case (bus.opcode)
            OP_LB, OP_LBU: begin
                is_load_s = 1'b1;
            end
            OP_LH, OP_LHU: begin
                is_load_s   = 1'b1;
                bad_align_s = bus.alu_result[0];
            end
            OP_LW: begin
                is_load_s   = 1'b1;
                bad_align_s = |bus.alu_result[1:0];
            end
            OP_SB: begin
                is_store_s = 1'b1;
                st_be_s    = 4'b0001 << bus.alu_result[1:0];
                st_wdata_s = {4{bus.rt_data[7:0]}};
            end
            OP_SH: begin
                is_store_s  = 1'b1;
                bad_align_s = bus.alu_result[0];
                st_be_s     = bus.alu_result[1] ? 4'b1100 : 4'b0011;
                st_wdata_s  = {2{bus.rt_data[15:0]}};
            end
            OP_SW: begin
                is_store_s  = 1'b1;
                bad_align_s = |bus.alu_result[1:0];
            end
            default: begin
                is_load_s  = 1'b0;
                is_store_s = 1'b0;
            end
        endcase
    end

    // Next-state and next-output logic of the access sequencer.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        op_s        = op_r;
        off_s       = off_r;
        dest_s      = dest_r;
        mem_addr_s  = mem_addr_r;
        mem_wdata_s = mem_wdata_r;
        mem_be_s    = mem_be_r;
        mem_read_s  = 1'b0;
        mem_write_s = 1'b0;
        wb_valid_s  = 1'b0;
        wb_reg_s    = wb_reg_r;
        wb_data_s   = wb_data_r;
        misalign_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.req_valid && (is_load_s || is_store_s)) begin
                    if (bad_align_s) begin
                        misalign_s = 1'b1;
                    end else begin
                        state_s     = ST_ACCESS;
                        op_s        = bus.opcode;
                        off_s       = bus.alu_result[1:0];
                        dest_s      = bus.dest_reg;
                        mem_addr_s  = bus.alu_result[ADDR_W+1:2];
                        mem_read_s  = is_load_s;
                        mem_write_s = is_store_s;
                        mem_be_s    = is_store_s ? st_be_s : 4'b1111;
                        mem_wdata_s = is_store_s ? st_wdata_s : mem_wdata_r;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (mem_read_r) begin
                    state_s = ST_WAIT;
                    cnt_s   = 4'd1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_r >= LAT) begin
                    state_s    = ST_DONE;
                    cnt_s      = 4'd0;
                    wb_valid_s = (dest_r != 5'd0);
                    wb_reg_s   = dest_r;
                    wb_data_s  = extract_load(op_r, off_r, bus.mem_rdata);
                end else begin
                    cnt_s = cnt_r + 4'd1;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = 4'd0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 4'd0;
            op_r        <= 6'd0;
            off_r       <= 2'd0;
            dest_r      <= 5'd0;
            mem_addr_r  <= '0;
            mem_wdata_r <= 32'd0;
            mem_be_r    <= 4'd0;
            mem_read_r  <= 1'b0;
            mem_write_r <= 1'b0;
            wb_valid_r  <= 1'b0;
            wb_reg_r    <= 5'd0;
            wb_data_r   <= 32'd0;
            misalign_r  <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            op_r        <= op_s;
            off_r       <= off_s;
            dest_r      <= dest_s;
            mem_addr_r  <= mem_addr_s;
            mem_wdata_r <= mem_wdata_s;
            mem_be_r    <= mem_be_s;
            mem_read_r  <= mem_read_s;
            mem_write_r <= mem_write_s;
            wb_valid_r  <= wb_valid_s;
            wb_reg_r    <= wb_reg_s;
            wb_data_r   <= wb_data_s;
            misalign_r  <= misalign_s;
        end
    end

    assign bus.req_ready    = (state_r == ST_IDLE) && !reset;
    assign bus.mem_addr     = mem_addr_r;
    assign bus.mem_wdata    = mem_wdata_r;
    assign bus.mem_be       = mem_be_r;
    assign bus.mem_read     = mem_read_r;
    assign bus.mem_write    = mem_write_r;
    assign bus.wb_valid     = wb_valid_r;
    assign bus.wb_reg       = wb_reg_r;
    assign bus.wb_data      = wb_data_r;
    assign bus.misalign_err = misalign_r;
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits directly upstream of the data memory: takes the EX-stage ALU address, store data and memory opcode, and drives a word-addressed data memory port with byte enables.
- Returns aligned, sign- or zero-extended load results to register writeback.
- A small FSM stalls the pipeline for the duration of each access.
- Detects misaligned halfword/word accesses and suppresses them.

Parameters:
- ADDR_W, 8, word-address width of the data memory (256 words).
- MEM_LATENCY, 1, cycles from the mem_read cycle to valid mem_rdata; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  EX stage presents a request this cycle.
- req_ready  out  1  unit can accept; pipeline stalls while low.
- opcode  in  6  MIPS primary opcode.
- alu_result  in  32  byte address.
- rt_data  in  32  store data.
- dest_reg  in  5  load destination register.
- mem_addr  out  ADDR_W  word address = alu_result[ADDR_W+1:2].
- mem_wdata  out  32  lane-replicated store data.
- mem_be  out  4  byte enables; bit k covers bits [8k+7:8k].
- mem_read  out  1  read strobe.
- mem_write  out  1  write strobe.
- mem_rdata  in  32  read data from memory.
- wb_valid  out  1  one-cycle writeback pulse.
- wb_reg  out  5  writeback register.
- wb_data  out  32  extended load data.
- misalign_err  out  1  one-cycle fault pulse.

Behaviour:
- One clock (clk); reset is synchronous and active-high.
- Reset values:
  - state IDLE; counter 0.
  - mem_addr, mem_wdata, mem_be, mem_read, mem_write, wb_valid, wb_reg, wb_data, misalign_err all 0.
  - req_ready = (state==IDLE) && !reset, so it is 0 while reset is high and 1 from the first cycle after release.
- Opcodes handled:
  - Loads: 0x20 lb, 0x21 lh, 0x23 lw, 0x24 lbu, 0x25 lhu.
  - Stores: 0x28 sb, 0x29 sh, 0x2B sw.
  - Any other opcode is accepted in IDLE and ignored: no state change, no outputs.
- Acceptance: only in IDLE when req_valid && req_ready. All inputs are registered at the accepting edge (cycle T); later input changes are ignored.
- Misalignment:
  - Fault conditions: lh/lhu/sh with addr[0]=1; lw/sw with addr[1:0]!=0.
  - Response: misalign_err=1 in T+1, no strobe, no writeback, state stays IDLE.
  - req_ready stays 1, so back-to-back faults are allowed.
- FSM states: IDLE -> ACCESS -> (store) IDLE, or (load) ACCESS -> WAIT -> DONE -> IDLE.
  - ACCESS (T+1): exactly one cycle of mem_read (loads) or mem_write (stores), with mem_addr, mem_be and mem_wdata valid.
  - WAIT: lasts MEM_LATENCY cycles (T+2 .. T+1+MEM_LATENCY). mem_rdata is captured at the rising edge ending cycle T+1+MEM_LATENCY.
  - DONE (T+2+MEM_LATENCY): wb_valid=1 with wb_reg and wb_data. Next cycle returns to IDLE.
  - Strobes are 0 in all states other than ACCESS. req_ready=0 in ACCESS, WAIT and DONE.
- Store lanes (little-endian):
  - sb: mem_be = 1<<addr[1:0]; mem_wdata = {4{rt[7:0]}}.
  - sh: mem_be = addr[1] ? 4'b1100 : 4'b0011; mem_wdata = {2{rt[15:0]}}.
  - sw: mem_be = 4'b1111; mem_wdata = rt.
- Load data extraction:
  - lb/lbu: byte at addr[1:0], sign- or zero-extended.
  - lh/lhu: halfword at addr[1], sign- or zero-extended.
  - lw: full word.
  - mem_be for loads = 4'b1111.
- dest_reg=0: the load still performs its memory read; wb_valid stays 0 in DONE.
- Address bits [31:ADDR_W+2] are ignored, so addresses wrap modulo 4*2^ADDR_W bytes.
- wb_data and wb_reg hold their values after the DONE pulse until the next load completes.
- Reset mid-operation: at the reset edge the FSM goes to IDLE and strobes and wb_valid clear. The in-flight access is abandoned and no writeback is issued.

Test Plan:
- sw to addr 0x10, rt=0xDEADBEEF -> T+1: mem_write=1, mem_addr=4, mem_be=1111, mem_wdata=0xDEADBEEF; req_ready back to 1 at T+2.
- sb to addr 0x13, rt=0x000000A5 -> mem_be=1000, mem_wdata=0xA5A5A5A5, mem_addr=4.
- lb from 0x12 with mem_rdata=0x1280FF00, MEM_LATENCY=1 -> mem_read at T+1; at T+3 wb_valid=1, wb_data=0xFFFFFF80.
  - Same case with lbu -> wb_data=0x00000080.
- lh at 0x02 with mem_rdata=0x8001FFFF -> wb_data=0xFFFF8001.
  - lhu at 0x02, same data -> 0x00008001.
  - MEM_LATENCY=3 -> wb_valid at T+5.
- lw at 0x06 -> misalign_err=1 at T+1, no mem_read, no wb_valid, req_ready stays 1.
  - lw at 0x08 with dest_reg=0 -> mem_read asserted, wb_valid never asserted.
- Reset asserted during WAIT of an lw -> next cycle: state IDLE, wb_valid=0, req_ready=0 while reset is high, 1 after release.
  - A new sw issued after release completes normally.
